// File: rtl/timer_counter_if.sv
// Register bus between the system bridge and the timer: byte address, write
// strobe, write data and combinational read data.
interface timer_counter_if;
  logic [31:0] addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;

  modport master (
    output addr,
    output we,
    output din,
    input  dout
  );

  modport slave (
    input  addr,
    input  we,
    input  din,
    output dout
  );
endinterface

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with one-shot and auto-reload modes,
// driving a single CP0 hardware interrupt line.
module timer_counter #(
  parameter int         COUNT_W  = 32,
  parameter logic [3:0] CTRL_RST = 4'h0
) (
  input  logic                  clk,
  input  logic                  reset,
  timer_counter_if.slave        bus,
  output logic                  irq
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  localparam logic [1:0]         SEL_CTRL   = 2'd0;
  localparam logic [1:0]         SEL_PRESET = 2'd1;
  localparam logic [1:0]         SEL_COUNT  = 2'd2;
  localparam logic [1:0]         MODE_RELOAD = 2'd1;
  localparam logic [COUNT_W-1:0] CNT_ZERO   = {COUNT_W{1'b0}};
  localparam logic [COUNT_W-1:0] CNT_ONE    = {{(COUNT_W-1){1'b0}}, 1'b1};

  state_t               state_q,    state_d;
  logic [3:0]           ctrl_q,     ctrl_d;
  logic [COUNT_W-1:0]   preset_q,   preset_d;
  logic [COUNT_W-1:0]   count_q,    count_d;
  logic                 irq_flag_q, irq_flag_d;

  logic        enable_s;
  logic [1:0]  mode_s;
  logic        int_mask_s;
  logic [1:0]  sel_s;
  logic        flag_set_s;
  logic        ack_write_s;
  logic [31:0] rdata_s;
  logic        unused_bus_s;

  assign enable_s   = ctrl_q[0];
  assign mode_s     = ctrl_q[2:1];
  assign int_mask_s = ctrl_q[3];
  assign sel_s      = bus.addr[3:2];

  assign unused_bus_s = ^{bus.addr[31:4], bus.addr[1:0], bus.din};

  // Any bus write to CTRL or PRESET acknowledges a pending interrupt.
  assign ack_write_s = bus.we && ((sel_s == SEL_CTRL) || (sel_s == SEL_PRESET));

  // Register state update with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ctrl_q     <= CTRL_RST;
      preset_q   <= CNT_ZERO;
      count_q    <= CNT_ZERO;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  // Next-state: FSM first, then bus writes so a CTRL write overrides the
  // one-shot Enable clear, while a flag set still beats an acknowledge.
  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;
    flag_set_s = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable_s) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!enable_s) begin
          state_d = ST_IDLE;
        end else if (count_q > CNT_ONE) begin
          count_d = count_q - CNT_ONE;
        end else begin
          count_d    = CNT_ZERO;
          irq_flag_d = 1'b1;
          flag_set_s = 1'b1;
          state_d    = ST_INT;
        end
      end
      ST_INT: begin
        if (mode_s == MODE_RELOAD) begin
          irq_flag_d = 1'b0;
        end else begin
          ctrl_d[0] = 1'b0;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (bus.we) begin
      case (sel_s)
        SEL_CTRL:   ctrl_d   = bus.din[3:0];
        SEL_PRESET: preset_d = bus.din[COUNT_W-1:0];
        default:    ctrl_d   = ctrl_d;
      endcase
    end else begin
      ctrl_d = ctrl_d;
    end

    if (ack_write_s && !flag_set_s) begin
      irq_flag_d = 1'b0;
    end else begin
      irq_flag_d = irq_flag_d;
    end
  end

  // Read mux; COUNT_W-wide registers are zero-extended to the bus width.
  always_comb begin
    rdata_s = 32'd0;
    case (sel_s)
      SEL_CTRL:   rdata_s[3:0]         = ctrl_q;
      SEL_PRESET: rdata_s[COUNT_W-1:0] = preset_q;
      SEL_COUNT:  rdata_s[COUNT_W-1:0] = count_q;
      default:    rdata_s              = 32'd0;
    endcase
  end

  assign bus.dout = rdata_s;
  assign irq      = irq_flag_q & int_mask_s;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: a vector table for single-edge register
// and one-shot behaviour, plus hand sequences for reload, races and reset.
module tb_timer_counter;

  logic clk;
  logic reset;
  logic irq;

  timer_counter_if bus_if ();

  timer_counter #(
    .COUNT_W  (32),
    .CTRL_RST (4'h0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic [31:0] exp_dout;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[$];
  int   checks;
  int   errors;

  function automatic vec_t mk(input logic we, input logic [31:0] waddr,
                              input logic [31:0] wdata, input logic [31:0] raddr,
                              input logic [31:0] exp_dout, input logic exp_irq);
    vec_t v;
    v.we = we; v.waddr = waddr; v.wdata = wdata;
    v.raddr = raddr; v.exp_dout = exp_dout; v.exp_irq = exp_irq;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One clock edge with the given bus write (or none), inputs settle #1 after.
  task automatic step(input logic we, input logic [31:0] a, input logic [31:0] d);
    bus_if.addr = a;
    bus_if.we   = we;
    bus_if.din  = d;
    @(posedge clk);
    #1;
    bus_if.we   = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    bus_if.addr = a;
    #1;
    v = bus_if.dout;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    logic        exp_i;
    checks = 0;
    errors = 0;
    reset = 1'b0;
    bus_if.addr = 32'd0;
    bus_if.we   = 1'b0;
    bus_if.din  = 32'd0;

    // one-shot count, acknowledge and decode
    vecs.push_back(mk(1'b1, 32'h4, 32'd3, 32'h4, 32'd3, 1'b0));
    vecs.push_back(mk(1'b1, 32'h0, 32'h9, 32'h0, 32'h9, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0, 32'h0, 32'h8, 32'd0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0, 32'h0, 32'h8, 32'd3, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0, 32'h0, 32'h8, 32'd2, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0, 32'h0, 32'h8, 32'd1, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0, 32'h0, 32'h8, 32'd0, 1'b1));
    vecs.push_back(mk(1'b0, 32'h0, 32'h0, 32'h0, 32'h8, 1'b1));
    vecs.push_back(mk(1'b0, 32'h0, 32'h0, 32'h8, 32'd0, 1'b1));
    vecs.push_back(mk(1'b1, 32'h0, 32'h8, 32'h0, 32'h8, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0, 32'h0, 32'h8, 32'd0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0, 32'h0, 32'hC, 32'd0, 1'b0));
    // masked expiry: flag sets silently, CTRL write clears it
    vecs.push_back(mk(1'b1, 32'h4, 32'd2, 32'h4, 32'd2, 1'b0));
    vecs.push_back(mk(1'b1, 32'h0, 32'h1, 32'h0, 32'h1, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0, 32'h0, 32'h8, 32'd0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0, 32'h0, 32'h8, 32'd2, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0, 32'h0, 32'h8, 32'd1, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0, 32'h0, 32'h8, 32'd0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0));
    vecs.push_back(mk(1'b1, 32'h0, 32'h8, 32'h0, 32'h8, 1'b0));
    // pause at 5, ignored writes, re-enable reloads PRESET
    vecs.push_back(mk(1'b1, 32'h4, 32'd7, 32'h4, 32'd7, 1'b0));
    vecs.push_back(mk(1'b1, 32'h0, 32'h9, 32'h0, 32'h9, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0, 32'h0, 32'h8, 32'd0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0, 32'h0, 32'h8, 32'd7, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0, 32'h0, 32'h8, 32'd6, 1'b0));
    vecs.push_back(mk(1'b1, 32'h0, 32'h8, 32'h8, 32'd5, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0, 32'h0, 32'h8, 32'd5, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0, 32'h0, 32'h8, 32'd5, 1'b0));
    vecs.push_back(mk(1'b1, 32'h8, 32'h55, 32'h8, 32'd5, 1'b0));
    vecs.push_back(mk(1'b1, 32'hC, 32'hFFFF, 32'hC, 32'd0, 1'b0));
    vecs.push_back(mk(1'b1, 32'h0, 32'h9, 32'h8, 32'd5, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0, 32'h0, 32'h8, 32'd5, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0, 32'h0, 32'h8, 32'd7, 1'b0));
    vecs.push_back(mk(1'b1, 32'h0, 32'h0, 32'h8, 32'd6, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0, 32'h0, 32'h8, 32'd6, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0));
    // read-only CTRL upper bits, full-width PRESET
    vecs.push_back(mk(1'b1, 32'h0, 32'hFFFF_FFF8, 32'h0, 32'h8, 1'b0));
    vecs.push_back(mk(1'b1, 32'h4, 32'hDEAD_BEEF, 32'h4, 32'hDEAD_BEEF, 1'b0));
    vecs.push_back(mk(1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0));

    do_reset();
    rd(32'h0, r); chk("rst_ctrl", r, 32'h0);
    rd(32'h4, r); chk("rst_preset", r, 32'h0);
    rd(32'h8, r); chk("rst_count", r, 32'h0);
    chk("rst_irq", {31'd0, irq}, 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].we, vecs[i].waddr, vecs[i].wdata);
      rd(vecs[i].raddr, r);
      chk($sformatf("vec%0d_dout", i), r, vecs[i].exp_dout);
      chk($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, vecs[i].exp_irq});
    end

    // auto-reload: one-cycle pulse every PRESET+3 = 7 cycles
    step(1'b1, 32'h4, 32'd4);
    step(1'b1, 32'h0, 32'hB);
    for (int c = 1; c <= 34; c++) begin
      step(1'b0, 32'h0, 32'h0);
      exp_i = (c >= 6) && (((c - 6) % 7) == 0);
      chk($sformatf("reload_irq_c%0d", c), {31'd0, irq}, {31'd0, exp_i});
    end
    rd(32'h0, r); chk("reload_ctrl", r, 32'hB);
    step(1'b1, 32'h0, 32'h0);
    do_reset();

    // flag set beats PRESET ack; CTRL write beats one-shot Enable clear
    step(1'b1, 32'h4, 32'd1);
    step(1'b1, 32'h0, 32'h9);
    step(1'b0, 32'h0, 32'h0);
    step(1'b0, 32'h0, 32'h0);
    step(1'b1, 32'h4, 32'd5);
    chk("setwins_irq", {31'd0, irq}, 32'd1);
    rd(32'h4, r); chk("setwins_preset", r, 32'd5);
    step(1'b1, 32'h0, 32'hB);
    rd(32'h0, r); chk("buswins_ctrl", r, 32'hB);
    chk("buswins_irq", {31'd0, irq}, 32'd0);
    step(1'b0, 32'h0, 32'h0);
    step(1'b0, 32'h0, 32'h0);
    rd(32'h8, r); chk("reload5_count", r, 32'd5);
    step(1'b0, 32'h0, 32'h0);
    rd(32'h8, r); chk("reload5_count2", r, 32'd4);

    // reset while counting
    do_reset();
    rd(32'h0, r); chk("rst2_ctrl", r, 32'h0);
    rd(32'h4, r); chk("rst2_preset", r, 32'h0);
    rd(32'h8, r); chk("rst2_count", r, 32'h0);
    chk("rst2_irq", {31'd0, irq}, 32'd0);
    step(1'b0, 32'h0, 32'h0);
    rd(32'h8, r); chk("rst2_idle_count", r, 32'h0);

    // PRESET=0 reaches INT three edges after the enabling write
    step(1'b1, 32'h0, 32'h9);
    step(1'b0, 32'h0, 32'h0);
    step(1'b0, 32'h0, 32'h0);
    chk("p0_irq_e2", {31'd0, irq}, 32'd0);
    step(1'b0, 32'h0, 32'h0);
    chk("p0_irq_e3", {31'd0, irq}, 32'd1);
    step(1'b0, 32'h0, 32'h0);
    rd(32'h0, r); chk("p0_ctrl", r, 32'h8);
    chk("p0_irq_hold", {31'd0, irq}, 32'd1);

    // reset with interrupt pending
    do_reset();
    chk("rst3_irq", {31'd0, irq}, 32'd0);
    rd(32'h0, r); chk("rst3_ctrl", r, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
